// File: rtl/pll_reset_sequencer.sv
// PLL bring-up controller: sequences PLL RESETB, qualifies LOCK, releases the
// PLL-domain reset, retries on timeout and latches a fault after too many tries.
// Runs from the board clock so it keeps working while the PLL is unlocked.
module pll_reset_sequencer #(
  parameter int unsigned RESET_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT    = 16000,
  parameter int unsigned STABLE_CYCLES   = 1024,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned BLINK_BIT       = 23,
  parameter int unsigned FAULT_BLINK_BIT = 20,
  localparam int unsigned RCW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           PLL_LOCK,
  output logic           PLL_RESETB,
  output logic           SYS_RST,
  output logic           READY,
  output logic           FAULT,
  output logic [RCW-1:0] RETRY_CNT,
  output logic           LED
);

  localparam int unsigned TMAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0]  RST_LAST    = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0]  LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]  STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [RCW-1:0] RETRY_MAX   = RCW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RCW-1:0]     retry_q, retry_d;
  logic               lock_meta, lock_s;
  logic [BLINK_BIT:0] blink_q, blink_d;
  logic               resetb_d, sys_rst_d, ready_d, fault_d, led_d;

  assign RETRY_CNT = retry_q;

  // Two-flop synchronizer for the asynchronous PLL LOCK signal.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  // Next state, timer, retry count and the registered output values for the
  // state being entered (outputs are decoded from state_d so they change on
  // the same edge as the state).
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    blink_d = blink_q + 1'b1;

    case (state_q)
      ST_PLLRST: begin
        if (timer_q == RST_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (timer_q == LOCK_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_PLLRST;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (timer_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) state_d = ST_PLLRST;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_PLLRST;
      end
    endcase

    // Timer restarts on every state change and idles at zero in RUN/FAULT.
    timer_d = timer_q + 1'b1;
    if ((state_d != state_q) || (state_q == ST_RUN) || (state_q == ST_FAULT)) timer_d = '0;

    resetb_d  = (state_d == ST_WAIT) || (state_d == ST_STABLE) || (state_d == ST_RUN);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);

    case (state_d)
      ST_RUN:   led_d = blink_d[BLINK_BIT];
      ST_FAULT: led_d = blink_d[FAULT_BLINK_BIT];
      default:  led_d = 1'b1;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_PLLRST;
      timer_q    <= '0;
      retry_q    <= '0;
      blink_q    <= '0;
      PLL_RESETB <= 1'b0;
      SYS_RST    <= 1'b1;
      READY      <= 1'b0;
      FAULT      <= 1'b0;
      LED        <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      blink_q    <= blink_d;
      PLL_RESETB <= resetb_d;
      SYS_RST    <= sys_rst_d;
      READY      <= ready_d;
      FAULT      <= fault_d;
      LED        <= led_d;
    end
  end

endmodule
